risc32_intc: RTL and testbench

Eight-source interrupt controller sitting directly upstream of `risc32_core`: it collects external interrupt lines, synchronizes, latches and masks them, then drives the core's single `interrupt` input. It completes the `interrupt`/`interrupt_ack` handshake by capturing the winning source ID, and holds off further requests until software writes end-of-interrupt. Software configures it through a small 4-register port that the core reaches via its I/O path.

---
 rtl/risc32_intc_if.sv | 27 ++
 rtl/risc32_intc.sv | 134 +++++++++++++
 tb/tb_risc32_intc.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/risc32_intc_if.sv
// Bus between risc32_core (master) and risc32_intc (slave).
//   interrupt      intc -> core  registered interrupt request
//   interrupt_ack  core -> intc  acknowledge, sampled on clk
//   vector         intc -> core  ID of the source in service
//   in_service     intc -> core  high from the accepted ack until EOI
//   cfg_we/addr/wdata core -> intc  register write port
//   cfg_rdata      intc -> core  combinational register read
interface risc32_intc_if;
  logic       interrupt;
  logic       interrupt_ack;
  logic [2:0] vector;
  logic       in_service;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;

  modport master (
    input  interrupt, vector, in_service, cfg_rdata,
    output interrupt_ack, cfg_we, cfg_addr, cfg_wdata
  );

  modport slave (
    output interrupt, vector, in_service, cfg_rdata,
    input  interrupt_ack, cfg_we, cfg_addr, cfg_wdata
  );
endinterface

// File: rtl/risc32_intc.sv
// Eight-source interrupt controller in front of risc32_core.
// Synchronizes irq_in, latches it into PENDING (edge or level per MODE),
// masks it, and runs the interrupt/interrupt_ack handshake. No nesting:
// further requests wait until software writes EOI.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   irq_in  asynchronous interrupt sources, bit 0 highest priority
//   bus     risc32_intc_if slave (handshake + register port)
//
// Registers: 0 MASK (R/W), 1 PENDING (R, W1C edge bits), 2 MODE (R/W,
// 1 = rising edge), 3 write = EOI, read = {in_service, 4'b0, vector}.
//
// state   | meaning
// IDLE    | no request outstanding, waiting for req
// REQ     | interrupt asserted, waiting for ack or withdrawal
// SERVICE | source accepted, waiting for EOI
module risc32_intc #(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    irq_in,
  risc32_intc_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t     state, state_n;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] sync_prev;
  logic [7:0] mask, pending, mode;
  logic [7:0] pending_n;
  logic       interrupt_q, in_service_q;
  logic [2:0] vector_q;

  logic       mask_wr, w1c_wr, mode_wr, eoi;
  logic [7:0] sync_lvl, rise, mask_eff, active, w1c, mode_chg, acc_clr;
  logic       req, accept;
  logic [2:0] win_id;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~sync_prev;

  assign mask_wr  = bus.cfg_we && (bus.cfg_addr == 2'd0);
  assign w1c_wr   = bus.cfg_we && (bus.cfg_addr == 2'd1);
  assign mode_wr  = bus.cfg_we && (bus.cfg_addr == 2'd2);
  assign eoi      = bus.cfg_we && (bus.cfg_addr == 2'd3);

  // A MASK write acts on the request on its own edge.
  assign mask_eff = mask_wr ? bus.cfg_wdata : mask;
  assign active   = pending & mask_eff;
  assign req      = |active;

  assign w1c      = w1c_wr  ? bus.cfg_wdata : 8'h00;
  assign mode_chg = mode_wr ? (bus.cfg_wdata ^ mode) : 8'h00;
  assign acc_clr  = accept  ? (8'h01 << win_id) : 8'h00;

  always_comb begin
    win_id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) win_id = 3'(i);
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE:    if (req) state_n = REQ;
      REQ: begin
        if (!req) begin
          state_n = IDLE;
        end else if (bus.interrupt_ack) begin
          state_n = SERVICE;
          accept  = 1'b1;
        end
      end
      SERVICE: if (eoi) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Per-bit pending update; for edge bits a new set beats any clear.
  always_comb begin
    pending_n = pending;
    for (int i = 0; i < 8; i++) begin
      if (mode_chg[i])             pending_n[i] = 1'b0;
      else if (!mode[i])           pending_n[i] = sync_lvl[i];
      else if (rise[i])            pending_n[i] = 1'b1;
      else if (w1c[i] | acc_clr[i]) pending_n[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
      sync_prev    <= 8'h00;
      mask         <= 8'h00;
      mode         <= 8'h00;
      pending      <= 8'h00;
      state        <= IDLE;
      interrupt_q  <= 1'b0;
      in_service_q <= 1'b0;
      vector_q     <= 3'd0;
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_prev    <= sync_lvl;
      if (mask_wr) mask <= bus.cfg_wdata;
      if (mode_wr) mode <= bus.cfg_wdata;
      pending      <= pending_n;
      state        <= state_n;
      interrupt_q  <= (state_n == REQ);
      in_service_q <= (state_n == SERVICE);
      if (accept) vector_q <= win_id;
    end
  end

  assign bus.interrupt  = interrupt_q;
  assign bus.in_service = in_service_q;
  assign bus.vector     = vector_q;

  always_comb begin
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata = mask;
      2'd1:    bus.cfg_rdata = pending;
      2'd2:    bus.cfg_rdata = mode;
      default: bus.cfg_rdata = {in_service_q, 4'b0000, vector_q};
    endcase
  end

endmodule

// File: tb/tb_risc32_intc.sv
// Directed self-checking bench for risc32_intc (SYNC_STAGES = 2).
module tb_risc32_intc;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] irq_in = 8'h00;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rv;

  risc32_intc_if bus ();

  risc32_intc #(.SYNC_STAGES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.cfg_addr = a;
    #1;
    d = bus.cfg_rdata;
  endtask

  initial begin
    bus.interrupt_ack = 1'b0;
    bus.cfg_we        = 1'b0;
    bus.cfg_addr      = 2'd0;
    bus.cfg_wdata     = 8'h00;
    #12 reset = 1'b1;
    tick();

    // reset state
    check("rst_interrupt", {7'b0, bus.interrupt}, 8'h00);
    check("rst_in_service", {7'b0, bus.in_service}, 8'h00);
    rd(2'd0, rv); check("rst_mask", rv, 8'h00);
    rd(2'd3, rv); check("rst_status", rv, 8'h00);

    // basic edge-mode flow on irq_in[0]
    cfg_write(2'd0, 8'h01);
    cfg_write(2'd2, 8'h01);
    irq_in = 8'h01;
    tick(); tick(); tick();
    check("t1_int_early", {7'b0, bus.interrupt}, 8'h00);
    rd(2'd1, rv); check("t1_pending_set", rv, 8'h01);
    tick();
    check("t1_int_up", {7'b0, bus.interrupt}, 8'h01);
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
    check("t1_int_down", {7'b0, bus.interrupt}, 8'h00);
    check("t1_vector", {5'b0, bus.vector}, 8'h00);
    check("t1_in_service", {7'b0, bus.in_service}, 8'h01);
    rd(2'd1, rv); check("t1_pending_clr", rv, 8'h00);
    // ack while in service is ignored
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
    check("t1_ack_ignored", {7'b0, bus.in_service}, 8'h01);
    cfg_write(2'd3, 8'h00);
    check("t1_eoi", {7'b0, bus.in_service}, 8'h00);
    tick();
    check("t1_no_reassert", {7'b0, bus.interrupt}, 8'h00);
    irq_in = 8'h00;
    repeat (4) tick();

    // priority between sources 5 and 2
    cfg_write(2'd2, 8'hFF);
    cfg_write(2'd0, 8'hFF);
    irq_in = 8'h24;
    tick(); tick(); tick();
    irq_in = 8'h00;
    tick();
    check("t2_int_up", {7'b0, bus.interrupt}, 8'h01);
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
    check("t2_vector_2", {5'b0, bus.vector}, 8'h02);
    rd(2'd1, rv); check("t2_pending_20", rv, 8'h20);
    rd(2'd3, rv); check("t2_status", rv, 8'h82);
    cfg_write(2'd3, 8'h00);
    check("t2_eoi_int", {7'b0, bus.interrupt}, 8'h00);
    tick();
    check("t2_reassert", {7'b0, bus.interrupt}, 8'h01);
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
    check("t2_vector_5", {5'b0, bus.vector}, 8'h05);
    rd(2'd1, rv); check("t2_pending_empty", rv, 8'h00);
    cfg_write(2'd3, 8'h00);
    repeat (2) tick();

    // level mode withdrawal on irq_in[3]
    cfg_write(2'd2, 8'h00);
    cfg_write(2'd0, 8'h08);
    irq_in = 8'h08;
    repeat (4) tick();
    check("t3_int_up", {7'b0, bus.interrupt}, 8'h01);
    irq_in = 8'h00;
    tick(); tick(); tick();
    check("t3_int_held", {7'b0, bus.interrupt}, 8'h01);
    tick();
    check("t3_int_withdrawn", {7'b0, bus.interrupt}, 8'h00);
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
    check("t3_late_ack", {7'b0, bus.in_service}, 8'h00);
    check("t3_late_ack_int", {7'b0, bus.interrupt}, 8'h00);

    // masking and W1C vs simultaneous set
    cfg_write(2'd0, 8'h00);
    cfg_write(2'd2, 8'h80);
    irq_in = 8'h80;
    repeat (3) tick();
    irq_in = 8'h00;
    repeat (3) tick();
    rd(2'd1, rv); check("t4_pending_80", rv, 8'h80);
    check("t4_masked_int", {7'b0, bus.interrupt}, 8'h00);
    irq_in = 8'h80;
    tick(); tick();
    cfg_write(2'd1, 8'h80);
    rd(2'd1, rv); check("t4_set_wins", rv, 8'h80);
    irq_in = 8'h00;
    repeat (3) tick();
    cfg_write(2'd1, 8'h80);
    rd(2'd1, rv); check("t4_w1c_clears", rv, 8'h00);

    // no nesting while in service
    cfg_write(2'd2, 8'hFF);
    cfg_write(2'd0, 8'hFF);
    irq_in = 8'h10;
    repeat (3) tick();
    irq_in = 8'h00;
    tick();
    check("t5_int_up", {7'b0, bus.interrupt}, 8'h01);
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
    check("t5_vector_4", {5'b0, bus.vector}, 8'h04);
    irq_in = 8'h02;
    repeat (3) tick();
    irq_in = 8'h00;
    repeat (2) tick();
    check("t5_no_nest", {7'b0, bus.interrupt}, 8'h00);
    rd(2'd1, rv); check("t5_pending_02", rv, 8'h02);
    cfg_write(2'd3, 8'h00);
    check("t5_eoi_int", {7'b0, bus.interrupt}, 8'h00);
    tick();
    check("t5_reassert", {7'b0, bus.interrupt}, 8'h01);

    // asynchronous reset in the middle of the handshake
    rd(2'd0, rv); check("t6_mask_before", rv, 8'hFF);
    reset = 1'b0;
    #1;
    check("t6_rst_int", {7'b0, bus.interrupt}, 8'h00);
    check("t6_rst_in_service", {7'b0, bus.in_service}, 8'h00);
    check("t6_rst_vector", {5'b0, bus.vector}, 8'h00);
    reset = 1'b1;
    rd(2'd0, rv); check("t6_mask_after", rv, 8'h00);
    rd(2'd1, rv); check("t6_pending_after", rv, 8'h00);
    rd(2'd2, rv); check("t6_mode_after", rv, 8'h00);
    tick();
    check("t6_int_stays_low", {7'b0, bus.interrupt}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
